fft_frame_loader: RTL
=====================

# fft_frame_loader

Streaming-to-frame front end for the `fft` core. It accepts signed audio samples one at a time over a valid/ready handshake, scales and truncates each sample to `DATA_WIDTH`, and assembles N samples into the packed complex frame the FFT consumes, with the imaginary parts set to zero. It double-buffers, so capture of the next frame continues while the FFT processes the current one. It issues one start pulse per frame and waits for the FFT's completion pulse before presenting the next frame.

## Interface
- `N`, 16: samples per frame, a power of two ≥ 2.
- `DATA_WIDTH`, 16: FFT real/imag word width.
- `SAMPLE_WIDTH`, 24: input sample width; must be ≥ `DATA_WIDTH`.
- `SHIFT`, 0: left-shift gain applied before truncation, 0..7.

Ports:
- `clk`  in  1  — clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `sample_in`  in  SAMPLE_WIDTH  — signed two's-complement sample.
- `sample_valid`  in  1  — `sample_in` is valid this cycle.
- `sample_ready`  out  1  — loader can accept a sample.
- `clr_overflow`  in  1  — synchronous clear of `overflow`.
- `frame_out`  out  DATA_WIDTH*N*2  — packed complex frame. Sample k real is at `[k*2*DATA_WIDTH +: DATA_WIDTH]`; imag is the next `DATA_WIDTH` bits up and is always 0.
- `fft_en`  out  1  — one-cycle start pulse to the FFT.
- `fft_done`  in  1  — one-cycle completion pulse from the FFT (its `en_out`).
- `overflow`  out  1  — sticky: a sample was offered while `sample_ready` was low.

## Operation
- **Fill side:** write index `wr_idx` runs 0..N-1. Flag `full` marks that the fill buffer holds N samples.
  - A sample is accepted when `sample_valid & sample_ready` at a rising edge.
  - On accept, the scaled sample goes to slot `wr_idx` and `wr_idx` increments.
  - When slot N-1 is written, `wr_idx` wraps to 0 and `full` sets.
- `sample_ready = !full` (combinational from a register).
- **Scaling:**
  1. Sign-extend the sample.
  2. Shift left by `SHIFT`.
  3. Saturate to the `SAMPLE_WIDTH` signed range.
  4. Take the top `DATA_WIDTH` bits.
- **Output FSM** has two states, IDLE and BUSY.
  - Transfer condition: `full & (state==IDLE | (state==BUSY & fft_done))`.
  - On a transfer edge: copy the fill buffer to `frame_out`, clear `full`, set `fft_en` for the next cycle, and go to (or stay in) BUSY.
  - BUSY with `fft_done` and no `full`: go to IDLE.
  - `fft_done` while in IDLE is ignored.
- `frame_out` is stable from the transfer edge until the next transfer edge.
- **Overflow:** if `sample_valid & !sample_ready`, the sample is discarded and `overflow` sets.
  - `clr_overflow` clears `overflow`.
  - If a set condition and `clr_overflow` occur in the same cycle, set wins.
- **Reset (including mid-frame):** `wr_idx`=0, `full`=0, state=IDLE, `frame_out`=0, `fft_en`=0, `overflow`=0, fill buffer contents don't-care. As a result, `sample_ready`=1 during and after reset.

## Timing
- Nth sample accepted at edge E:
  - `full`=1 after E, so `sample_ready`=0 for one cycle.
  - Transfer at edge E+1 if the FSM is IDLE.
  - `fft_en` is high between E+1 and E+2.
  - `sample_ready` returns to 1 after E+1.
- Latency from last sample accepted to `fft_en` high: 1 cycle.
- Maximum sustained rate when the FFT is idle: N samples per N+1 cycles.
- While BUSY with `full`=1, `sample_ready` stays low until the edge on which `fft_done` is seen; the transfer happens on that same edge.
- `fft_en` is never high for two consecutive cycles. `frame_out` never changes while BUSY except at a transfer edge.

## Structure
- Package `fft_pkg`:
  - default `N`/`DATA_WIDTH`/`SAMPLE_WIDTH` constants;
  - FSM state enum (IDLE, BUSY);
  - index helper functions for the real and imaginary slice offsets within the packed frame.
- Sub-module `fft_sample_scaler`: combinational shift, saturate and truncate, parameterised by `SAMPLE_WIDTH`, `DATA_WIDTH` and `SHIFT`.
- Top level holds the fill buffer, counters, FSM and output register.

## Test plan
- **Reset:** assert `rst` mid-run → `frame_out`=0, `fft_en`=0, `overflow`=0, `sample_ready`=1.
- **Single frame,** `SHIFT`=0:
  - Stimulus: 16 samples in the repeating pattern 24'h03E800, 0, 0, 0, 24'hFC1800, 0, 0, 0.
  - Expected: real slots 1000, 0, 0, 0, -1000, … with all imag 0; `fft_en` pulses exactly once, 1 cycle after the 16th accept.
- **Backpressure:**
  - Stimulus: no `fft_done`; offer 33 samples back-to-back.
  - Expected: after the second frame fills, `sample_ready`=0, the 33rd sample is dropped, `overflow`=1, and `frame_out` still holds frame 1.
  - Then: pulse `clr_overflow` → `overflow`=0.
- **Done/full coincidence:** `fft_done` on the same edge that `full` is seen in BUSY → immediate transfer, `fft_en` pulses again, state stays BUSY.
- **Saturation,** `SHIFT`=2: 24'h400000 → 16'h7FFF; 24'hC00000 → 16'h8000; 24'h001000 → 16'h0040.
- **Reset mid-fill:** accept 7 samples, pulse `rst`, then feed 16 new samples → `frame_out` contains only the new samples, starting at slot 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults, FSM state type and packed-frame slice helpers for the FFT front end.
package fft_pkg;
  localparam int N_DEF            = 16;
  localparam int DATA_WIDTH_DEF   = 16;
  localparam int SAMPLE_WIDTH_DEF = 24;

  typedef enum logic {IDLE, BUSY} state_t;

  // Complex word k occupies 2*dw bits: real in the low half, imag in the high half.
  function automatic int re_off(input int k, input int dw);
    return k * 2 * dw;
  endfunction

  function automatic int im_off(input int k, input int dw);
    return k * 2 * dw + dw;
  endfunction
endpackage

// File: rtl/fft_sample_scaler.sv
// Combinational gain stage: sign-extend, shift left by SHIFT, saturate to the
// input range, then keep the top DATA_WIDTH bits.
module fft_sample_scaler
  import fft_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int SHIFT        = 0
) (
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0]   scaled
);
  localparam int W = SAMPLE_WIDTH + SHIFT;

  logic signed [W-1:0]      wide;
  logic [SHIFT:0]           hi;
  logic [SAMPLE_WIDTH-1:0]  sat;

  always_comb begin
    wide = W'($signed(sample)) <<< SHIFT;
    // Bits above the input MSB must all match the sign, otherwise the shift overflowed.
    hi   = wide[W-1 -: SHIFT+1];
    if (&hi || !(|hi))
      sat = wide[SAMPLE_WIDTH-1:0];
    else if (wide[W-1])
      sat = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    else
      sat = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    scaled = sat[SAMPLE_WIDTH-1 -: DATA_WIDTH];
  end
endmodule

// File: rtl/fft_frame_loader.sv
// Streams scaled samples into a fill buffer and hands complete frames to the FFT,
// double-buffered against the output register, one start pulse per frame.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int SHIFT        = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SAMPLE_WIDTH-1:0]   sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic                      clr_overflow,
  output logic [DATA_WIDTH*N*2-1:0] frame_out,
  output logic                      fft_en,
  input  logic                      fft_done,
  output logic                      overflow
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = DATA_WIDTH * N * 2;

  logic [N-1:0][DATA_WIDTH-1:0] fill_buf;
  logic [IW-1:0]                wr_idx;
  logic                         full;
  logic                         accept;
  logic                         transfer;
  logic [DATA_WIDTH-1:0]        scaled;
  logic [FW-1:0]                frame_nxt;
  state_t                       state, state_nxt;

  assign sample_ready = !full;
  assign accept       = sample_valid & sample_ready;

  fft_sample_scaler #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .SHIFT        (SHIFT)
  ) u_scaler (
    .sample (sample_in),
    .scaled (scaled)
  );

  // Fill buffer contents are don't-care after reset; wr_idx/full gate their use.
  always_ff @(posedge clk) begin
    if (accept) fill_buf[wr_idx] <= scaled;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      full   <= 1'b0;
    end else if (accept) begin
      wr_idx <= wr_idx + 1'b1;
      if (wr_idx == IW'(N-1)) full <= 1'b1;
    end else if (transfer) begin
      full <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    transfer  = 1'b0;
    unique case (state)
      IDLE: if (full) begin
        transfer  = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (fft_done) begin
        if (full) transfer  = 1'b1;
        else      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    frame_nxt = '0;
    for (int k = 0; k < N; k++) begin
      frame_nxt[re_off(k, DATA_WIDTH) +: DATA_WIDTH] = fill_buf[k];
      frame_nxt[im_off(k, DATA_WIDTH) +: DATA_WIDTH] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_out <= '0;
      fft_en    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      fft_en <= transfer;
      if (transfer) frame_out <= frame_nxt;
      // A dropped sample outranks a clear in the same cycle.
      if (sample_valid && !sample_ready) overflow <= 1'b1;
      else if (clr_overflow)             overflow <= 1'b0;
    end
  end
endmodule
